// File: rtl/console_pkg.sv
// Shared definitions for the console writer: FSM encodings, control codes,
// screen geometry, copy/fill bounds and the byte classifier.
// Build option: CONSOLE_SCROLL_EN enables the scroll-by-copy states.
package console_pkg;

  localparam int COLS = 64;
  localparam int ROWS = 32;

  // Word addresses are {row[4:0], col[5:0]}
  localparam logic [10:0] ROW_WORDS   = 11'(COLS);
  localparam logic [10:0] SCROLL_LAST = 11'((ROWS - 1) * COLS - 1);  // 1983
  localparam logic [10:0] FILL_FIRST  = 11'((ROWS - 1) * COLS);      // 1984
  localparam logic [10:0] SCREEN_LAST = 11'(ROWS * COLS - 1);        // 2047

  localparam logic [5:0] LAST_COL = 6'(COLS - 1);
  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

  // FSM state encodings
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_PUT    = 3'd1;
`ifdef CONSOLE_SCROLL_EN
  localparam logic [2:0] ST_SCR_RD = 3'd2;
  localparam logic [2:0] ST_SCR_WR = 3'd3;
`endif
  localparam logic [2:0] ST_FILL   = 3'd4;

  // Control codes
  localparam logic [7:0] CC_BS    = 8'h08;
  localparam logic [7:0] CC_LF    = 8'h0A;
  localparam logic [7:0] CC_FF    = 8'h0C;
  localparam logic [7:0] CC_CR    = 8'h0D;
  localparam logic [7:0] CC_SPACE = 8'h20;

  typedef enum logic [2:0] {
    BC_PRINT = 3'd0,
    BC_CR    = 3'd1,
    BC_LF    = 3'd2,
    BC_BS    = 3'd3,
    BC_FF    = 3'd4
  } byte_class_e;

  // Anything that is not one of the four control codes is printed as-is.
  function automatic byte_class_e classify(input logic [7:0] c);
    case (c)
      CC_CR:   return BC_CR;
      CC_LF:   return BC_LF;
      CC_BS:   return BC_BS;
      CC_FF:   return BC_FF;
      default: return BC_PRINT;
    endcase
  endfunction

endpackage

// File: rtl/console_cursor.sv
// Cursor position registers for the console writer. Commands are one-cycle
// pulses; home has priority, then advance/CR/BS on the column, and the
// newline action (LF or wrapping advance) on the row.
// Build option: CONSOLE_SCROLL_EN keeps the row at the bottom on newline
// (the screen scrolls instead); otherwise the row wraps to 0.
module console_cursor
  import console_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       adv_i,
  input  logic       cr_i,
  input  logic       lf_i,
  input  logic       bs_i,
  input  logic       home_i,
  output logic [5:0] col_o,
  output logic [4:0] row_o,
  output logic       wrap_o,
  output logic       last_row_o
);

  logic [5:0] col_q, col_d;
  logic [4:0] row_q, row_d;
  logic       newline;

  assign col_o      = col_q;
  assign row_o      = row_q;
  assign wrap_o     = (col_q == LAST_COL);
  assign last_row_o = (row_q == LAST_ROW);

  // Next cursor position from the command pulses
  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    newline = lf_i | (adv_i & wrap_o);
    if (home_i) begin
      col_d = '0;
      row_d = '0;
    end else begin
      if (adv_i) begin
        col_d = wrap_o ? 6'd0 : col_q + 6'd1;
      end else if (cr_i) begin
        col_d = '0;
      end else if (bs_i && (col_q != 6'd0)) begin
        col_d = col_q - 6'd1;
      end
      if (newline) begin
        if (!last_row_o) begin
          row_d = row_q + 5'd1;
        end else begin
`ifdef CONSOLE_SCROLL_EN
          row_d = row_q;
`else
          row_d = '0;
`endif
        end
      end
    end
  end

  // Cursor registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

endmodule

// File: rtl/console_writer.sv
// Character-stream writer for the 64x32 text video RAM. Accepts bytes over
// valid/ready, handles CR/LF/BS/FF, writes {attr, char} words, and clears or
// scrolls the screen by driving the RAM write/read port itself.
// Build option: CONSOLE_SCROLL_EN enables scroll by RAM copy at the bottom
// row; without it the cursor wraps to row 0 and only FF makes the block busy.
module console_writer
  import console_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic [7:0]  CHAR_DATA,
  input  logic        CHAR_VALID,
  output logic        CHAR_READY,
  input  logic [7:0]  ATTR,
  output logic [10:0] ADDRESS,
  output logic [15:0] WDATA,
  output logic        WE,
  output logic        RE,
  input  logic [15:0] RDATA,
  output logic [5:0]  CURSOR_COL,
  output logic [4:0]  CURSOR_ROW,
  output logic        BUSY
);

  logic [2:0]  state_q, state_d;
  logic        we_q, we_d;
  logic        re_q, re_d;
  logic [10:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;

  logic        accept;
  byte_class_e cls;

  logic        cur_adv, cur_cr, cur_lf, cur_bs, cur_home;
  logic [5:0]  cur_col;
  logic [4:0]  cur_row;
  logic        cur_wrap, cur_last_row;

`ifdef CONSOLE_SCROLL_EN
  logic [10:0] idx_q, idx_d;     // destination word of the copy in progress
  logic [7:0]  attr_q, attr_d;   // attribute for the blank bottom row
  logic        copy_q, copy_d;   // WDATA comes from the RAM read port
  logic        start_scroll;
`else
  logic        unused_inputs;
  assign unused_inputs = ^{RDATA, cur_wrap, cur_last_row};
`endif

  assign CHAR_READY = (state_q == ST_IDLE) & ~RESET;
  assign accept     = CHAR_VALID & CHAR_READY;
  assign cls        = classify(CHAR_DATA);

  assign ADDRESS    = addr_q;
  assign WE         = we_q;
  assign RE         = re_q;
  assign CURSOR_COL = cur_col;
  assign CURSOR_ROW = cur_row;

`ifdef CONSOLE_SCROLL_EN
  // During the copy the write word is the RAM's own registered read data,
  // forwarded so each word takes one read cycle and one write cycle.
  assign WDATA = copy_q ? RDATA : wdata_q;
  assign BUSY  = (state_q == ST_SCR_RD) | (state_q == ST_SCR_WR) | (state_q == ST_FILL);
`else
  assign WDATA = wdata_q;
  assign BUSY  = (state_q == ST_FILL);
`endif

  console_cursor u_cursor (
    .clk_i      (CLK),
    .rst_i      (RESET),
    .adv_i      (cur_adv),
    .cr_i       (cur_cr),
    .lf_i       (cur_lf),
    .bs_i       (cur_bs),
    .home_i     (cur_home),
    .col_o      (cur_col),
    .row_o      (cur_row),
    .wrap_o     (cur_wrap),
    .last_row_o (cur_last_row)
  );

  // FSM next state, RAM port next values and cursor commands
  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    re_d     = re_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cur_adv  = 1'b0;
    cur_cr   = 1'b0;
    cur_lf   = 1'b0;
    cur_bs   = 1'b0;
    cur_home = 1'b0;
`ifdef CONSOLE_SCROLL_EN
    idx_d        = idx_q;
    attr_d       = attr_q;
    copy_d       = copy_q;
    start_scroll = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
`ifdef CONSOLE_SCROLL_EN
          attr_d = ATTR;
`endif
          case (cls)
            BC_CR: cur_cr = 1'b1;
            BC_BS: cur_bs = 1'b1;
            BC_LF: begin
              cur_lf = 1'b1;
`ifdef CONSOLE_SCROLL_EN
              start_scroll = cur_last_row;
`endif
            end
            BC_FF: begin
              cur_home = 1'b1;
              state_d  = ST_FILL;
              we_d     = 1'b1;
              addr_d   = '0;
              wdata_d  = {ATTR, CC_SPACE};
            end
            default: begin
              state_d = ST_PUT;
              we_d    = 1'b1;
              addr_d  = {cur_row, cur_col};
              wdata_d = {ATTR, CHAR_DATA};
            end
          endcase
        end
      end
      ST_PUT: begin
        // The word is written during this cycle; move the cursor after it.
        we_d    = 1'b0;
        cur_adv = 1'b1;
        state_d = ST_IDLE;
`ifdef CONSOLE_SCROLL_EN
        start_scroll = cur_wrap & cur_last_row;
`endif
      end
`ifdef CONSOLE_SCROLL_EN
      ST_SCR_RD: begin
        re_d    = 1'b0;
        we_d    = 1'b1;
        addr_d  = idx_q;
        copy_d  = 1'b1;
        state_d = ST_SCR_WR;
      end
      ST_SCR_WR: begin
        copy_d = 1'b0;
        if (idx_q == SCROLL_LAST) begin
          state_d = ST_FILL;
          addr_d  = FILL_FIRST;
          wdata_d = {attr_q, CC_SPACE};
        end else begin
          we_d    = 1'b0;
          re_d    = 1'b1;
          idx_d   = idx_q + 11'd1;
          addr_d  = idx_q + 11'd1 + ROW_WORDS;
          state_d = ST_SCR_RD;
        end
      end
`endif
      ST_FILL: begin
        if (addr_q == SCREEN_LAST) begin
          we_d    = 1'b0;
          state_d = ST_IDLE;
        end else begin
          addr_d = addr_q + 11'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        we_d    = 1'b0;
        re_d    = 1'b0;
      end
    endcase
`ifdef CONSOLE_SCROLL_EN
    // Begin copying row 1 onto row 0, reading one row ahead of the writes
    if (start_scroll) begin
      state_d = ST_SCR_RD;
      we_d    = 1'b0;
      re_d    = 1'b1;
      idx_d   = '0;
      addr_d  = ROW_WORDS;
      copy_d  = 1'b0;
    end
`endif
  end

  // FSM and registered RAM port; reset aborts any copy or fill at once
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
`ifdef CONSOLE_SCROLL_EN
      idx_q   <= '0;
      attr_q  <= '0;
      copy_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      re_q    <= re_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
`ifdef CONSOLE_SCROLL_EN
      idx_q   <= idx_d;
      attr_q  <= attr_d;
      copy_q  <= copy_d;
`endif
    end
  end

endmodule

// File: tb/tb_console_writer.sv
// Directed testbench for console_writer with a behavioural video RAM.
module tb_console_writer;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [7:0]  CHAR_DATA = 8'h00;
  logic        CHAR_VALID = 1'b0;
  logic        CHAR_READY;
  logic [7:0]  ATTR = 8'h00;
  logic [10:0] ADDRESS;
  logic [15:0] WDATA;
  logic        WE, RE;
  logic [15:0] RDATA;
  logic [5:0]  CURSOR_COL;
  logic [4:0]  CURSOR_ROW;
  logic        BUSY;

  int compared = 0;
  int mismatched = 0;

  logic [15:0] mem [0:2047];
  logic [15:0] rd_q = 16'h0000;
  int          wr_count = 0;
  int          rd_count = 0;
  int          overlap = 0;
  logic        poke_en = 1'b0;
  logic [10:0] poke_addr = '0;
  logic [15:0] poke_data = '0;

  assign RDATA = rd_q;

  always #5 CLK = ~CLK;

  console_writer dut (
    .CLK(CLK), .RESET(RESET), .CHAR_DATA(CHAR_DATA), .CHAR_VALID(CHAR_VALID),
    .CHAR_READY(CHAR_READY), .ATTR(ATTR), .ADDRESS(ADDRESS), .WDATA(WDATA),
    .WE(WE), .RE(RE), .RDATA(RDATA), .CURSOR_COL(CURSOR_COL),
    .CURSOR_ROW(CURSOR_ROW), .BUSY(BUSY)
  );

  // Video RAM: write port and registered read (latency 1)
  always @(posedge CLK) begin
    if (poke_en) mem[poke_addr] <= poke_data;
    if (WE) begin
      mem[ADDRESS] <= WDATA;
      wr_count <= wr_count + 1;
    end
    if (RE) begin
      rd_q <= mem[ADDRESS];
      rd_count <= rd_count + 1;
    end
    if (WE && RE) overlap <= overlap + 1;
  end

  task automatic poke(input logic [10:0] a, input logic [15:0] d);
    poke_addr = a; poke_data = d; poke_en = 1'b1;
    @(negedge CLK);
    poke_en = 1'b0;
  endtask

  // Returns at the negedge right after the accepting edge
  task automatic send(input logic [7:0] b, input logic [7:0] a);
    int n = 0;
    while (!CHAR_READY && n < 10000) begin
      @(negedge CLK); n++;
    end
    if (!CHAR_READY) begin
      $display("FAIL ready_timeout: CHAR_READY=%b required 1", CHAR_READY);
      mismatched++; compared++;
    end
    CHAR_DATA = b; ATTR = a; CHAR_VALID = 1'b1;
    @(negedge CLK);
    CHAR_VALID = 1'b0;
    $display("tx byte=%02h attr=%02h cursor=(%0d,%0d) busy=%b", b, a, CURSOR_COL, CURSOR_ROW, BUSY);
  endtask

  task automatic count_busy(output int n);
    if (!BUSY) @(negedge CLK);
    n = 0;
    while (BUSY && n < 6000) begin
      n++; @(negedge CLK);
    end
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
  endtask

  task automatic goto_last_row();
    do_reset();
    for (int i = 0; i < 31; i++) send(8'h0A, 8'h00);
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    repeat (3) @(negedge CLK);
    compared++; if (WE !== 1'b0 || RE !== 1'b0) begin $display("FAIL reset_we_re: got WE=%b RE=%b required 0/0", WE, RE); mismatched++; end
    compared++; if (ADDRESS !== 11'd0 || WDATA !== 16'h0000) begin $display("FAIL reset_addr_data: got %h/%h required 000/0000", ADDRESS, WDATA); mismatched++; end
    compared++; if (BUSY !== 1'b0 || CHAR_READY !== 1'b0) begin $display("FAIL reset_busy_ready: got BUSY=%b READY=%b required 0/0", BUSY, CHAR_READY); mismatched++; end
    compared++; if (CURSOR_COL !== 6'd0 || CURSOR_ROW !== 5'd0) begin $display("FAIL reset_cursor: got (%0d,%0d) required (0,0)", CURSOR_COL, CURSOR_ROW); mismatched++; end
    RESET = 1'b0;
    @(negedge CLK);
    compared++; if (CHAR_READY !== 1'b1) begin $display("FAIL reset_release_ready: got %b required 1", CHAR_READY); mismatched++; end
  endtask

  task automatic test_printable();
    send(8'h41, 8'h0E);
    compared++; if (WE !== 1'b1 || ADDRESS !== 11'd0 || WDATA !== 16'h0E41) begin $display("FAIL put_a: got WE=%b @%h %h required 1 @000 0e41", WE, ADDRESS, WDATA); mismatched++; end
    compared++; if (CHAR_READY !== 1'b0 || CURSOR_COL !== 6'd0) begin $display("FAIL put_a_ready: got READY=%b col=%0d required 0 col 0", CHAR_READY, CURSOR_COL); mismatched++; end
    @(negedge CLK);
    compared++; if (CHAR_READY !== 1'b1 || WE !== 1'b0 || CURSOR_COL !== 6'd1) begin $display("FAIL put_a_after: got READY=%b WE=%b col=%0d required 1 0 1", CHAR_READY, WE, CURSOR_COL); mismatched++; end
    send(8'h42, 8'h0E);
    compared++; if (WE !== 1'b1 || ADDRESS !== 11'd1 || WDATA !== 16'h0E42) begin $display("FAIL put_b: got WE=%b @%h %h required 1 @001 0e42", WE, ADDRESS, WDATA); mismatched++; end
    @(negedge CLK);
    compared++; if (CURSOR_COL !== 6'd2 || CURSOR_ROW !== 5'd0) begin $display("FAIL put_cursor: got (%0d,%0d) required (2,0)", CURSOR_COL, CURSOR_ROW); mismatched++; end
    compared++; if (mem[0] !== 16'h0E41 || mem[1] !== 16'h0E42) begin $display("FAIL put_mem: got %h %h required 0e41 0e42", mem[0], mem[1]); mismatched++; end
  endtask

  task automatic test_row_wrap();
    int w0;
    do_reset();
    w0 = wr_count;
    for (int i = 0; i < 64; i++) send(8'(8'h30 + i), 8'h07);
    repeat (3) @(negedge CLK);
    compared++; if (wr_count - w0 !== 64) begin $display("FAIL wrap_writes: got %0d required 64", wr_count - w0); mismatched++; end
    compared++; if (mem[63] !== 16'h076F) begin $display("FAIL wrap_last: got %h required 076f", mem[63]); mismatched++; end
    compared++; if (CURSOR_COL !== 6'd0 || CURSOR_ROW !== 5'd1) begin $display("FAIL wrap_cursor: got (%0d,%0d) required (0,1)", CURSOR_COL, CURSOR_ROW); mismatched++; end
  endtask

  task automatic test_clear();
    int w0, n;
    w0 = wr_count;
    send(8'h0C, 8'h00);
    compared++; if (WE !== 1'b1 || ADDRESS !== 11'd0 || WDATA !== 16'h0020) begin $display("FAIL ff_first: got WE=%b @%h %h required 1 @000 0020", WE, ADDRESS, WDATA); mismatched++; end
    count_busy(n);
    compared++; if (n !== 2048) begin $display("FAIL ff_busy: got %0d cycles required 2048", n); mismatched++; end
    compared++; if (wr_count - w0 !== 2048) begin $display("FAIL ff_writes: got %0d required 2048", wr_count - w0); mismatched++; end
    compared++; if (mem[0] !== 16'h0020 || mem[1000] !== 16'h0020 || mem[2047] !== 16'h0020) begin $display("FAIL ff_mem: got %h %h %h required 0020", mem[0], mem[1000], mem[2047]); mismatched++; end
    compared++; if (CURSOR_COL !== 6'd0 || CURSOR_ROW !== 5'd0 || CHAR_READY !== 1'b1) begin $display("FAIL ff_cursor: got (%0d,%0d) ready=%b required (0,0) 1", CURSOR_COL, CURSOR_ROW, CHAR_READY); mismatched++; end
  endtask

  task automatic test_bs_cr();
    int w0, r0;
    send(8'h08, 8'h00);
    compared++; if (CURSOR_COL !== 6'd0 || CURSOR_ROW !== 5'd0 || CHAR_READY !== 1'b1) begin $display("FAIL bs_col0: got (%0d,%0d) ready=%b required (0,0) 1", CURSOR_COL, CURSOR_ROW, CHAR_READY); mismatched++; end
    for (int i = 0; i < 3; i++) send(8'h0A, 8'h00);
    for (int i = 0; i < 10; i++) send(8'h2E, 8'h01);
    @(negedge CLK);
    compared++; if (CURSOR_COL !== 6'd10 || CURSOR_ROW !== 5'd3) begin $display("FAIL goto_10_3: got (%0d,%0d) required (10,3)", CURSOR_COL, CURSOR_ROW); mismatched++; end
    send(8'h08, 8'h00);
    compared++; if (CURSOR_COL !== 6'd9 || CHAR_READY !== 1'b1) begin $display("FAIL bs_dec: got col %0d ready=%b required 9 1", CURSOR_COL, CHAR_READY); mismatched++; end
    w0 = wr_count; r0 = rd_count;
    send(8'h0D, 8'h00);
    @(negedge CLK);
    compared++; if (CURSOR_COL !== 6'd0 || CURSOR_ROW !== 5'd3) begin $display("FAIL cr_cursor: got (%0d,%0d) required (0,3)", CURSOR_COL, CURSOR_ROW); mismatched++; end
    compared++; if (wr_count != w0 || rd_count != r0) begin $display("FAIL cr_noaccess: got %0d writes %0d reads required 0 0", wr_count - w0, rd_count - r0); mismatched++; end
  endtask

  task automatic test_scroll_lf();
    int w0, r0, n;
    goto_last_row();
    for (int i = 0; i < 3; i++) send(8'h78, 8'h02);
    @(negedge CLK);
    poke(11'd69, 16'h1234);
    poke(11'd1987, 16'hABCD);
    w0 = wr_count; r0 = rd_count;
    send(8'h0A, 8'h5A);
`ifdef CONSOLE_SCROLL_EN
    compared++; if (RE !== 1'b1 || WE !== 1'b0 || ADDRESS !== 11'd64) begin $display("FAIL scr_first: got RE=%b WE=%b @%h required 1 0 @040", RE, WE, ADDRESS); mismatched++; end
    count_busy(n);
    compared++; if (n !== 4032) begin $display("FAIL scr_busy: got %0d cycles required 4032", n); mismatched++; end
    compared++; if (wr_count - w0 !== 2048 || rd_count - r0 !== 1984) begin $display("FAIL scr_counts: got %0d writes %0d reads required 2048 1984", wr_count - w0, rd_count - r0); mismatched++; end
    compared++; if (mem[5] !== 16'h1234 || mem[1923] !== 16'hABCD) begin $display("FAIL scr_copy: got %h %h required 1234 abcd", mem[5], mem[1923]); mismatched++; end
    compared++; if (mem[1984] !== 16'h5A20 || mem[2047] !== 16'h5A20) begin $display("FAIL scr_fill: got %h %h required 5a20 5a20", mem[1984], mem[2047]); mismatched++; end
    compared++; if (CURSOR_COL !== 6'd3 || CURSOR_ROW !== 5'd31) begin $display("FAIL scr_cursor: got (%0d,%0d) required (3,31)", CURSOR_COL, CURSOR_ROW); mismatched++; end
`else
    count_busy(n);
    compared++; if (n !== 0) begin $display("FAIL lf_wrap_busy: got %0d cycles required 0", n); mismatched++; end
    compared++; if (wr_count != w0 || rd_count != r0) begin $display("FAIL lf_wrap_noaccess: got %0d writes %0d reads required 0 0", wr_count - w0, rd_count - r0); mismatched++; end
    compared++; if (CURSOR_COL !== 6'd3 || CURSOR_ROW !== 5'd0) begin $display("FAIL lf_wrap_cursor: got (%0d,%0d) required (3,0)", CURSOR_COL, CURSOR_ROW); mismatched++; end
`endif
  endtask

  task automatic test_wrap_scroll();
    int n;
    goto_last_row();
    for (int i = 0; i < 63; i++) send(8'h61, 8'h07);
    send(8'h5A, 8'h33);
    compared++; if (WE !== 1'b1 || ADDRESS !== 11'd2047 || WDATA !== 16'h335A) begin $display("FAIL corner_put: got WE=%b @%h %h required 1 @7ff 335a", WE, ADDRESS, WDATA); mismatched++; end
    count_busy(n);
`ifdef CONSOLE_SCROLL_EN
    compared++; if (n !== 4032) begin $display("FAIL corner_busy: got %0d cycles required 4032", n); mismatched++; end
    compared++; if (mem[1983] !== 16'h335A || mem[1920] !== 16'h0761 || mem[2047] !== 16'h3320) begin $display("FAIL corner_mem: got %h %h %h required 335a 0761 3320", mem[1983], mem[1920], mem[2047]); mismatched++; end
    compared++; if (CURSOR_COL !== 6'd0 || CURSOR_ROW !== 5'd31) begin $display("FAIL corner_cursor: got (%0d,%0d) required (0,31)", CURSOR_COL, CURSOR_ROW); mismatched++; end
`else
    compared++; if (n !== 0) begin $display("FAIL corner_busy: got %0d cycles required 0", n); mismatched++; end
    compared++; if (mem[2047] !== 16'h335A) begin $display("FAIL corner_mem: got %h required 335a", mem[2047]); mismatched++; end
    compared++; if (CURSOR_COL !== 6'd0 || CURSOR_ROW !== 5'd0) begin $display("FAIL corner_cursor: got (%0d,%0d) required (0,0)", CURSOR_COL, CURSOR_ROW); mismatched++; end
`endif
  endtask

  task automatic test_reset_mid_busy();
    int w0, r0;
`ifdef CONSOLE_SCROLL_EN
    send(8'h0A, 8'h11);
`else
    send(8'h0C, 8'h11);
`endif
    repeat (100) @(negedge CLK);
    compared++; if (BUSY !== 1'b1) begin $display("FAIL mid_busy: got %b required 1", BUSY); mismatched++; end
    RESET = 1'b1;
    @(negedge CLK);
    w0 = wr_count; r0 = rd_count;
    compared++; if (WE !== 1'b0 || RE !== 1'b0 || BUSY !== 1'b0) begin $display("FAIL abort_port: got WE=%b RE=%b BUSY=%b required 0 0 0", WE, RE, BUSY); mismatched++; end
    compared++; if (CURSOR_COL !== 6'd0 || CURSOR_ROW !== 5'd0 || CHAR_READY !== 1'b0) begin $display("FAIL abort_cursor: got (%0d,%0d) ready=%b required (0,0) 0", CURSOR_COL, CURSOR_ROW, CHAR_READY); mismatched++; end
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    repeat (5) @(negedge CLK);
    compared++; if (wr_count != w0 || rd_count != r0) begin $display("FAIL abort_noaccess: got %0d writes %0d reads required 0 0", wr_count - w0, rd_count - r0); mismatched++; end
    compared++; if (CHAR_READY !== 1'b1 || BUSY !== 1'b0) begin $display("FAIL abort_release: got READY=%b BUSY=%b required 1 0", CHAR_READY, BUSY); mismatched++; end
  endtask

  initial begin
    test_reset();
    test_printable();
    test_row_wrap();
    test_clear();
    test_bs_cr();
    test_scroll_lf();
    test_wrap_scroll();
    test_reset_mid_busy();
    compared++; if (overlap != 0) begin $display("FAIL we_re_overlap: got %0d cycles required 0", overlap); mismatched++; end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
